// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control unit.
// Used by pipe_hazard_ctrl and hazard_loaduse_det.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Architectural zero register: never a real producer, so never a hazard.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOADUSE = 2'd1,
    CAUSE_MEMWAIT = 2'd2,
    CAUSE_ERROR   = 2'd3
  } stall_cause_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pipe_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } pipe_flush_t;

  localparam pipe_en_t    EN_ALL   = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
  localparam pipe_en_t    EN_NONE  = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
  localparam pipe_flush_t FL_NONE  = '{if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0};
  localparam pipe_flush_t FL_ALL   = '{if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1};

endpackage

// File: rtl/hazard_loaduse_det.sv
// Combinational load-use detector: the load in EX writes a register the
// instruction in ID reads.
module hazard_loaduse_det
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  output logic                  loaduse_c
);

  assign loaduse_c = ex_memread && (ex_rd != ZERO_REG) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush control with memory-wait timeout supervision.
// Define PIPE_HAZARD_CTRL_PERF_EN to add the stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  mem_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  en_pc,
  output logic                  en_if_id,
  output logic                  en_id_ex,
  output logic                  en_ex_mem,
  output logic                  en_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [1:0]            stall_cause,
  output logic                  mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_loaduse_cnt,
  output logic [CNT_W-1:0]      perf_memwait_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(MEM_TIMEOUT);

  if ((MEM_TIMEOUT < 1) || (CNT_W < 1)) begin : g_bad_params
    $error("pipe_hazard_ctrl: MEM_TIMEOUT and CNT_W must be at least 1");
  end

  ctrl_state_e       state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              loaduse_c;
  logic              mem_pending_c;
  logic              redirect_c;
  pipe_en_t          en_c;
  pipe_flush_t       flush_c;
  stall_cause_e      cause_c;

  hazard_loaduse_det u_loaduse (
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_rd     (ex_rd),
    .ex_memread(ex_memread),
    .loaduse_c (loaduse_c)
  );

  assign mem_pending_c = dmem_req && !dmem_ack;

  // Priority resolve: freeze > redirect > load-use; zero latency from inputs.
  always_comb begin
    en_c       = EN_ALL;
    flush_c    = FL_NONE;
    cause_c    = CAUSE_NONE;
    redirect_c = 1'b0;
    if (state == ST_ERROR) begin
      en_c    = EN_NONE;
      cause_c = CAUSE_ERROR;
    end else if (mem_pending_c) begin
      en_c    = EN_NONE;
      cause_c = CAUSE_MEMWAIT;
    end else if (mem_redirect) begin
      flush_c    = FL_ALL;
      redirect_c = 1'b1;
    end else if (loaduse_c) begin
      en_c.pc       = 1'b0;
      en_c.if_id    = 1'b0;
      flush_c.id_ex = 1'b1;
      cause_c       = CAUSE_LOADUSE;
    end
  end

  assign en_pc        = en_c.pc;
  assign en_if_id     = en_c.if_id;
  assign en_id_ex     = en_c.id_ex;
  assign en_ex_mem    = en_c.ex_mem;
  assign en_mem_wb    = en_c.mem_wb;
  assign flush_if_id  = flush_c.if_id;
  assign flush_id_ex  = flush_c.id_ex;
  assign flush_ex_mem = flush_c.ex_mem;
  assign stall_cause  = cause_c;

  // Memory handshake supervisor; ERROR is terminal until reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (mem_pending_c) state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (dmem_ack) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCNT_LAST) begin
            state    <= ST_ERROR;
            wait_cnt <= WCNT_SAT;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        ST_ERROR: begin
          wait_cnt <= WCNT_SAT;
          mem_err  <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Free-running event counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_loaduse_cnt <= '0;
      perf_memwait_cnt <= '0;
      perf_flush_cnt   <= '0;
    end else begin
      if (cause_c == CAUSE_LOADUSE) perf_loaduse_cnt <= perf_loaduse_cnt + CNT_W'(1);
      if (cause_c == CAUSE_MEMWAIT) perf_memwait_cnt <= perf_memwait_cnt + CNT_W'(1);
      if (redirect_c)               perf_flush_cnt   <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes predicted outputs,
// a negedge monitor pops and compares. Honors PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, mem_redirect, dmem_req, dmem_ack;
  logic       en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] stall_cause;
  logic       mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_loaduse_cnt, perf_memwait_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .mem_redirect(mem_redirect),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .en_pc       (en_pc),
    .en_if_id    (en_if_id),
    .en_id_ex    (en_id_ex),
    .en_ex_mem   (en_ex_mem),
    .en_mem_wb   (en_mem_wb),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .flush_ex_mem(flush_ex_mem),
    .stall_cause (stall_cause),
    .mem_err     (mem_err)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_loaduse_cnt(perf_loaduse_cnt),
    .perf_memwait_cnt(perf_memwait_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0] en;     // pc, if_id, id_ex, ex_mem, mem_wb
    logic [2:0] fl;     // if_id, id_ex, ex_mem
    logic [1:0] cause;
    logic       err;
    logic [31:0] lu;
    logic [31:0] mw;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: error flag, "inside a memory wait" flag, unacked wait count.
  bit          m_err, m_inwait;
  int          m_waits;
  int unsigned m_lu, m_mw, m_fc;

  task automatic model_reset();
    m_err = 0; m_inwait = 0; m_waits = 0;
    m_lu = 0; m_mw = 0; m_fc = 0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit   hazard;
    hazard = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    e.en = 5'b11111; e.fl = 3'b000; e.cause = 2'd0;
    if (m_err) begin
      e.en = 5'b00000; e.cause = 2'd3;
    end else if (dmem_req && !dmem_ack) begin
      e.en = 5'b00000; e.cause = 2'd2;
    end else if (mem_redirect) begin
      e.fl = 3'b111;
    end else if (hazard) begin
      e.en = 5'b00111; e.fl = 3'b010; e.cause = 2'd1;
    end
    e.err = m_err;
    e.lu  = m_lu % (32'd1 << CNT_W);
    e.mw  = m_mw % (32'd1 << CNT_W);
    e.fc  = m_fc % (32'd1 << CNT_W);
    return e;
  endfunction

  task automatic model_advance(input exp_t e);
    if (e.cause == 2'd1) m_lu++;
    if (e.cause == 2'd2) m_mw++;
    if (e.fl == 3'b111) m_fc++;
    if (m_err) return;
    if (m_inwait) begin
      if (dmem_ack) m_inwait = 0;
      else if (m_waits + 1 == int'(MEM_TIMEOUT)) begin m_err = 1; m_inwait = 0; end
      else m_waits++;
    end else if (dmem_req && !dmem_ack) begin
      m_inwait = 1; m_waits = 0;
    end
  endtask

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr, input logic redir,
                      input logic req, input logic ack);
    exp_t e;
    @(posedge clk); #1;
    arst_n = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_memread = mr; mem_redirect = redir; dmem_req = req; dmem_ack = ack;
    if (!rst) model_reset();
    e = predict();
    exp_q.push_back(e);
    if (rst) model_advance(e);
  endtask

  task automatic idle();
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("enables", 32'({en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}), 32'(e.en));
      chk("flushes", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'(e.fl));
      chk("stall_cause", 32'(stall_cause), 32'(e.cause));
      chk("mem_err", 32'(mem_err), 32'(e.err));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("perf_loaduse_cnt", 32'(perf_loaduse_cnt), e.lu);
      chk("perf_memwait_cnt", 32'(perf_memwait_cnt), e.mw);
      chk("perf_flush_cnt", 32'(perf_flush_cnt), e.fc);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_memread = 1'b0; mem_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    model_reset();

    // Reset and idle
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // Load-use on rs2, then the same pattern against x0
    step(1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // Redirect overrides load-use
    step(1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    // Single-cycle access
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    // Three-cycle wait then ack
    repeat (3) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    // Timeout into ERROR, late ack ignored, reset clears
    repeat (7) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // Ack on the last allowed wait cycle wins
    repeat (4) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    // Redirect held across a memory wait
    repeat (2) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    // Reset mid-wait
    repeat (2) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    // Counter scenario: 3 load-use, 5 wait cycles, 2 redirects, then 2 more load-use
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
    end
    repeat (3) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      step(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
    end
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rst, req, ack;
      rst = m_err ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) != 0);
      req = m_inwait ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 2) == 0);
      step(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), req, ack);
    end
    idle();

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
